coretest_bus_arbiter: RTL

//  Two-master arbiter for the 32-bit memory-like core bus (cs/we/address/write_data/read_data/error).

---
 rtl/coretest_bus_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/coretest_bus_arbiter.sv
// Two-master round-robin arbiter for the coretest memory-like core bus.
// One access in flight: request captured at grant, one cs cycle, one ack cycle.
module coretest_bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_write_data,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_read_data,
    output logic              m0_error,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_write_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_read_data,
    output logic              m1_error,
    output logic              core_cs,
    output logic              core_we,
    output logic [ADDR_W-1:0] core_address,
    output logic [DATA_W-1:0] core_write_data,
    input  logic [DATA_W-1:0] core_read_data,
    input  logic              core_error,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              grant;
    logic              grant_sel;
    logic              owner;
    logic              last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_sel  = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant      = 1'b1;
                    state_next = ACCESS;
                    // On a tie the master that did not win last time goes first
                    if (m0_req && m1_req) begin
                        grant_sel = ~last_grant;
                    end else begin
                        grant_sel = m1_req;
                    end
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            m0_read_data <= '0;
            m0_error     <= 1'b0;
            m1_read_data <= '0;
            m1_error     <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                owner      <= grant_sel;
                last_grant <= grant_sel;
                we_q       <= grant_sel ? m1_we : m0_we;
                addr_q     <= grant_sel ? m1_address : m0_address;
                wdata_q    <= grant_sel ? m1_write_data : m0_write_data;
            end
            // Writes keep the previous read data; error follows every access
            if (state == ACCESS) begin
                if (owner) begin
                    m1_error <= core_error;
                    if (!we_q) begin
                        m1_read_data <= core_read_data;
                    end
                end else begin
                    m0_error <= core_error;
                    if (!we_q) begin
                        m0_read_data <= core_read_data;
                    end
                end
            end
        end
    end

    assign core_cs         = (state == ACCESS);
    assign core_we         = core_cs & we_q;
    assign core_address    = core_cs ? addr_q : '0;
    assign core_write_data = core_cs ? wdata_q : '0;
    assign m0_ack          = (state == RESP) && !owner && !reset;
    assign m1_ack          = (state == RESP) && owner && !reset;
    assign busy            = (state != IDLE);

endmodule
